// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer: FSM state encoding,
// default baud divisor and frame length. The frame length and the parity
// helper depend on the optional macro UART_TX_PARITY_EN.
package uart_pkg;

    // 50 MHz system clock / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    // The PARITY encoding is reserved even when parity is not built in
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

`ifdef UART_TX_PARITY_EN
    // start + 8 data + parity + stop
    localparam int unsigned FRAME_BITS = 11;

    // Even parity over one data byte
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`else
    // start + 8 data + stop
    localparam int unsigned FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO in front of the UART serializer. Pointers wrap
// naturally (FIFO_DEPTH is a power of two); the occupancy count is one bit
// wider so that full and empty are both decoded directly from it.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [7:0]                    din,
    output logic [7:0]                    dout,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_s    = (count_r == CW'(FIFO_DEPTH));
    assign empty_s   = (count_r == CW'(0));
    assign push_ok_s = push && !full_s;
    assign pop_ok_s  = pop && !empty_s;

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

    // Next occupancy: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; cleared on reset so no stale byte is ever observable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Read/write pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Write-only UART transmitter behind the MMU's UART window. Store bytes
// strobed by UARTEnable are queued in uart_tx_fifo and serialized 8N1,
// LSB first, on tx. uartfull back-pressures the MMU.
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (11 bit periods per frame).
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       UARTEnable,
    input  logic [7:0] wr_data,
    output logic       uartfull,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    tx_state_e     state_r;
    logic [7:0]    shift_r;
    logic [BW-1:0] baud_r;
    logic [2:0]    bit_idx_r;
    logic          tx_r;
    logic          busy_r;
`ifdef UART_TX_PARITY_EN
    logic          parity_r;
`endif

    logic          push_s;
    logic          pop_s;
    logic          baud_end_s;
    logic [7:0]    fifo_dout_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;

    // A write is taken only when the registered full flag is clear, so a
    // write in the same cycle as the freeing pop is still refused
    assign push_s     = UARTEnable && !fifo_full_s;
    assign pop_s      = (state_r == ST_IDLE) && !fifo_empty_s;
    assign baud_end_s = (baud_r == BW'(CLKS_PER_BIT - 1));

    assign uartfull = (fifo_count_s == CW'(FIFO_DEPTH));
    assign tx       = tx_r;
    assign busy     = busy_r;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (wr_data),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Frame serializer: state, baud counter, shifter and registered tx/busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'h00;
            baud_r    <= BW'(0);
            bit_idx_r <= 3'd0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        // Pop the head and drive the start bit next cycle
                        shift_r   <= fifo_dout_s;
                        baud_r    <= BW'(0);
                        bit_idx_r <= 3'd0;
                        tx_r      <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_START;
`ifdef UART_TX_PARITY_EN
                        parity_r  <= even_parity(fifo_dout_s);
`endif
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= push_s;
                    end
                end

                ST_START: begin
                    if (baud_end_s) begin
                        baud_r  <= BW'(0);
                        tx_r    <= shift_r[0];
                        state_r <= ST_DATA;
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end

                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_r <= BW'(0);
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_r    <= parity_r;
                            state_r <= ST_PARITY;
`else
                            tx_r    <= 1'b1;
                            state_r <= ST_STOP;
`endif
                        end else begin
                            shift_r   <= {1'b0, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_end_s) begin
                        baud_r  <= BW'(0);
                        tx_r    <= 1'b1;
                        state_r <= ST_STOP;
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (baud_end_s) begin
                        // No pop happens in STOP, so the FIFO is non-empty
                        // after this edge iff it is now or a push lands now
                        baud_r  <= BW'(0);
                        tx_r    <= 1'b1;
                        busy_r  <= !fifo_empty_s || push_s;
                        state_r <= ST_IDLE;
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a safe idle line
                    baud_r  <= BW'(0);
                    tx_r    <= 1'b1;
                    busy_r  <= !fifo_empty_s;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// A queue-based reference model predicts tx/busy/uartfull every cycle and
// an independent line decoder recovers the bytes actually sent on tx.
module tb_uart_tx_buffer;
    import uart_pkg::*;

    localparam int CPB       = 4;
    localparam int DEPTH     = 8;
    localparam int FB        = FRAME_BITS;
    localparam int FRAME_CYC = FB * CPB;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       UARTEnable = 1'b0;
    logic [7:0] wr_data    = 8'h00;
    logic       uartfull;
    logic       tx;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_buffer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .UARTEnable (UARTEnable),
        .wr_data    (wr_data),
        .uartfull   (uartfull),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned mq[$];     // bytes waiting in the buffer
    byte unsigned sent[$];   // bytes the model has started sending
    int           ecyc      = 0;
    int           eng_free  = 0;  // first edge at which the engine may pop
    int           pop_edge  = 0;
    bit           have_frame = 1'b0;
    logic [10:0]  cur_frame = '1;

    function automatic logic [10:0] make_frame(input logic [7:0] b);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        f[9] = 1'($countones(b) % 2);
`endif
        return f;
    endfunction

    function automatic bit in_flight();
        return have_frame && ((ecyc - pop_edge) < FRAME_CYC);
    endfunction

    function automatic logic exp_tx();
        if (in_flight()) return cur_frame[(ecyc - pop_edge) / CPB];
        return 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        have_frame = 1'b0;
        eng_free   = ecyc;
    endtask

    task automatic model_step(input logic en, input logic [7:0] d);
        bit full_b;
        byte unsigned b;
        ecyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        full_b = (mq.size() == DEPTH);
        if (ecyc >= eng_free && mq.size() > 0) begin
            b = mq.pop_front();
            sent.push_back(b);
            cur_frame  = make_frame(b);
            pop_edge   = ecyc;
            have_frame = 1'b1;
            eng_free   = ecyc + FRAME_CYC + 1;
        end
        if (en && !full_b) mq.push_back(d);
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic step_cycle(input logic en, input logic [7:0] d);
        UARTEnable = en;
        wr_data    = d;
        @(posedge clk);
        model_step(en, d);
        @(negedge clk);
        check("tx", tx, exp_tx());
        check("busy", busy, in_flight() || (mq.size() > 0));
        check("uartfull", uartfull, mq.size() == DEPTH);
    endtask

    task automatic drain();
        int g = 0;
        while ((mq.size() > 0 || in_flight()) && g < 5000) begin
            step_cycle(1'b0, 8'h00);
            g++;
        end
        check("drain_bound", g < 5000, 1);
        repeat (3) step_cycle(1'b0, 8'h00);
    endtask

    // ---------------- independent line decoder ----------------
    logic         mon_act   = 1'b0;
    int           mon_cnt   = 0;
    logic [7:0]   mon_byte  = 8'h00;
    int           frame_err = 0;
    byte unsigned rxq[$];

    // Sample each bit mid-period, counted from the first low sample
    always @(negedge clk) begin : line_monitor
        if (!rst_n) begin
            mon_act <= 1'b0;
            mon_cnt <= 0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act <= 1'b1;
                mon_cnt <= 0;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if ((mon_cnt + 1) % CPB == CPB / 2) begin
                if ((mon_cnt + 1) / CPB == 0) begin
                    if (tx !== 1'b0) frame_err <= frame_err + 1;
                end else if ((mon_cnt + 1) / CPB <= 8) begin
                    mon_byte <= {tx, mon_byte[7:1]};
`ifdef UART_TX_PARITY_EN
                end else if ((mon_cnt + 1) / CPB == 9) begin
                    if (tx !== 1'($countones(mon_byte) % 2)) frame_err <= frame_err + 1;
`endif
                end else begin
                    if (tx !== 1'b1) frame_err <= frame_err + 1;
                    rxq.push_back(mon_byte);
                    mon_act <= 1'b0;
                end
            end
        end
    end

    task automatic check_rx(input byte unsigned expq[$], input string nm);
        check({nm, "_count"}, rxq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            check(nm, rxq[i], expq[i]);
        check({nm, "_framing"}, frame_err, 0);
        rxq.delete();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0]  data;
        logic [10:0] bits;      // serial bits, index 0 = start bit
        int          busy_len;  // cycles from write edge until busy reads 0
    } vec_t;

    vec_t         vecs[5];
    byte unsigned expq[$];
    logic [10:0]  got;
    int           first_idle;
    int           g;

    initial begin
`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'hA5, 11'b1_0_10100101_0, 45};
        vecs[1] = '{8'h00, 11'b1_0_00000000_0, 45};
        vecs[2] = '{8'hFF, 11'b1_0_11111111_0, 45};
        vecs[3] = '{8'h3C, 11'b1_0_00111100_0, 45};
        vecs[4] = '{8'h07, 11'b1_1_00000111_0, 45};
`else
        vecs[0] = '{8'hA5, 11'b0_1_10100101_0, 41};
        vecs[1] = '{8'h00, 11'b0_1_00000000_0, 41};
        vecs[2] = '{8'hFF, 11'b0_1_11111111_0, 41};
        vecs[3] = '{8'h3C, 11'b0_1_00111100_0, 41};
        vecs[4] = '{8'h07, 11'b0_1_00000111_0, 41};
`endif

        // Reset state
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_uartfull", uartfull, 0);
        rst_n = 1'b1;

        // Reset idle: quiet line for 100 cycles
        repeat (100) step_cycle(1'b0, 8'h00);

        // Single-byte frames from the table
        for (int i = 0; i < 5; i++) begin
            step_cycle(1'b1, vecs[i].data);
            check("tbl_tx_pre", tx, 1);
            got        = '1;
            first_idle = -1;
            for (int c = 1; c <= FRAME_CYC + 1; c++) begin
                step_cycle(1'b0, 8'h00);
                if (c == 1) check("tbl_fall", tx, 0);
                if (c % CPB == 3 && c <= FRAME_CYC) got[(c - 1) / CPB] = tx;
                if (busy == 1'b0 && first_idle < 0) first_idle = c;
            end
            check("tbl_bits", got[FB-1:0], vecs[i].bits[FB-1:0]);
            check("tbl_busy_len", first_idle, vecs[i].busy_len);
            repeat (2) step_cycle(1'b0, 8'h00);
        end
        expq.delete();
        for (int i = 0; i < 5; i++) expq.push_back(vecs[i].data);
        check_rx(expq, "tbl_rx");

        // Fill and overflow: 9 accepted, the 10th (0xFF) dropped
        for (int i = 0; i < 9; i++) step_cycle(1'b1, 8'(i));
        check("fill_full", uartfull, 1);
        step_cycle(1'b1, 8'hFF);
        check("fill_still_full", uartfull, 1);
        drain();
        expq.delete();
        for (int i = 0; i < 9; i++) expq.push_back(8'(i));
        check_rx(expq, "fill_rx");

        // Full release: writes held while full, including the pop cycle, are refused
        for (int i = 0; i < 9; i++) step_cycle(1'b1, 8'(8'h10 + i));
        g = 0;
        while (uartfull === 1'b1 && g < 200) begin
            step_cycle(1'b1, 8'hEE);
            g++;
        end
        check("release_bound", g < 200, 1);
        step_cycle(1'b1, 8'h77);
        drain();
        expq.delete();
        for (int i = 0; i < 9; i++) expq.push_back(8'(8'h10 + i));
        expq.push_back(8'h77);
        check_rx(expq, "release_rx");

        // Reset during data bit 3 of 0x3C
        step_cycle(1'b1, 8'h3C);
        for (int c = 1; c <= 18; c++) step_cycle(1'b0, 8'h00);
        check("mid_bit3", tx, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_uartfull", uartfull, 0);
        @(negedge clk);
        repeat (3) step_cycle(1'b0, 8'h00);
        rst_n = 1'b1;
        repeat (2) step_cycle(1'b0, 8'h00);
        check("midrst_no_rx", rxq.size(), 0);
        step_cycle(1'b1, 8'h55);
        drain();
        expq.delete();
        expq.push_back(8'h55);
        check_rx(expq, "midrst_rx");

        // Randomized traffic: heavy load (exercises full) then sparse writes
        sent.delete();
        rxq.delete();
        for (int c = 0; c < 1500; c++)
            step_cycle(($urandom_range(0, 2) == 0), 8'($urandom));
        for (int c = 0; c < 1500; c++)
            step_cycle(($urandom_range(0, 49) == 0), 8'($urandom));
        drain();
        check_rx(sent, "rand_rx");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
